layer_scheduler: RTL

//  Sequences up to NUM_ENG compute engines (activation, matmul, ...) from one PS go/done handshake.

---
 rtl/layer_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : layer_scheduler
// Purpose  : Runs the enabled compute engines one after another from a single
//            PS go/done handshake. Owns the BRAM mux select and a watchdog.
// Revision : 1.0  initial release
// ============================================================================
module layer_scheduler #(
    parameter int NUM_ENG = 4,
    parameter int TIMEOUT = 65535,
    parameter int SEL_W   = $clog2(NUM_ENG + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ps_control,
    output logic [31:0]        pl_status,
    output logic [NUM_ENG-1:0] eng_start,
    input  logic [NUM_ENG-1:0] eng_done,
    output logic [SEL_W-1:0]   bram_sel,
    output logic               executing
);

    localparam int c_WD_W = $clog2(TIMEOUT + 1);
    localparam int c_PAD  = 1 << SEL_W;

    localparam logic [c_WD_W-1:0] c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0]  c_IDX_END  = SEL_W'(NUM_ENG);
    localparam logic [SEL_W-1:0]  c_IDX_ONE  = SEL_W'(1);
    localparam logic [15:0]       c_CNT_MAX  = 16'hFFFF;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SCAN    = 3'd1;
    localparam logic [2:0] c_START   = 3'd2;
    localparam logic [2:0] c_RELEASE = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;
    localparam logic [2:0] c_ERR     = 3'd5;

    logic [2:0]         r_state, w_state;
    logic [SEL_W-1:0]   r_idx, w_idx;
    logic [NUM_ENG-1:0] r_mask, w_mask;
    logic [15:0]        r_cnt, w_cnt, w_cnt_inc;
    logic [c_WD_W-1:0]  r_wd, w_wd;
    logic               r_armed;
    logic               r_done, r_err, r_busy, r_exec;
    logic [NUM_ENG-1:0] r_start;
    logic [SEL_W-1:0]   r_sel;

    logic               w_go, w_launch, w_wd_hit, w_own_bram;
    logic [c_PAD-1:0]   w_mask_ext, w_done_ext;
    logic               w_unused;

    assign w_go       = ps_control[0];
    // Padding lets the scan index reach NUM_ENG without an out-of-range select.
    assign w_mask_ext = c_PAD'(r_mask);
    assign w_done_ext = c_PAD'(eng_done);
    assign w_launch   = (r_state == c_IDLE) && w_go && r_armed;
    assign w_wd_hit   = (r_wd == c_WD_LAST);
    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 16'd1;
    assign w_own_bram = (w_state == c_START) || (w_state == c_RELEASE);
    assign w_unused   = ^{ps_control[31:8+NUM_ENG], ps_control[7:1]};

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_mask  = r_mask;
        w_cnt   = r_cnt;
        w_wd    = r_wd;
        case (r_state)
            c_IDLE: begin
                if (w_launch) begin
                    w_state = c_SCAN;
                    w_idx   = '0;
                    w_mask  = ps_control[8 +: NUM_ENG];
                    w_cnt   = '0;
                end
            end
            c_SCAN: begin
                w_cnt = w_cnt_inc;
                if (r_idx == c_IDX_END) begin
                    w_state = c_DONE;
                end else if (w_mask_ext[r_idx]) begin
                    w_state = c_START;
                    w_wd    = '0;
                end else begin
                    w_idx = r_idx + c_IDX_ONE;
                end
            end
            c_START: begin
                w_cnt = w_cnt_inc;
                w_wd  = r_wd + c_WD_W'(1);
                // Timeout takes priority over a done edge in the same cycle.
                if (w_wd_hit) begin
                    w_state = c_ERR;
                end else if (w_done_ext[r_idx]) begin
                    w_state = c_RELEASE;
                end
            end
            c_RELEASE: begin
                w_cnt = w_cnt_inc;
                w_wd  = r_wd + c_WD_W'(1);
                if (w_wd_hit) begin
                    w_state = c_ERR;
                end else if (!w_done_ext[r_idx]) begin
                    w_state = c_SCAN;
                    w_idx   = r_idx + c_IDX_ONE;
                end
            end
            c_DONE, c_ERR: begin
                if (!w_go) begin
                    w_state = c_IDLE;
                end
            end
            default: w_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_armed <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_exec  <= 1'b0;
            r_start <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_mask  <= w_mask;
            r_cnt   <= w_cnt;
            r_wd    <= w_wd;
            // A new run needs go to have been seen low since the last launch.
            if (!w_go) begin
                r_armed <= 1'b1;
            end else if (w_launch) begin
                r_armed <= 1'b0;
            end
            r_done  <= (w_state == c_DONE) || (w_state == c_ERR);
            r_err   <= (w_state == c_ERR);
            r_busy  <= (w_state == c_SCAN) || w_own_bram;
            r_exec  <= w_own_bram;
            r_start <= (w_state == c_START) ? (NUM_ENG'(1) << w_idx) : '0;
            r_sel   <= w_own_bram ? (w_idx + c_IDX_ONE) : '0;
        end
    end

    assign pl_status = {r_cnt, 9'd0, 3'(r_idx), 1'b0, r_busy, r_err, r_done};
    assign eng_start = r_start;
    assign bram_sel  = r_sel;
    assign executing = r_exec;

endmodule
`default_nettype wire
